// File: rtl/coralnpu_axi_master_engine.sv
// Single-outstanding AXI4 burst master: runs one INCR read or write burst per
// command. Write data is streamed from wd_*, read data is forwarded to rd_*,
// and a one-cycle done pulse reports the ID and the burst response.
module coralnpu_axi_master_engine #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 128,
  parameter int IDWIDTH = 6
) (
  input  logic                clk,
  input  logic                resetn,
  // command
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AWIDTH-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [IDWIDTH-1:0]  cmd_id,
  // write-data stream
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DWIDTH-1:0]   wd_data,
  input  logic [DWIDTH/8-1:0] wd_strb,
  // read-data stream
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DWIDTH-1:0]   rd_data,
  output logic [1:0]          rd_resp,
  output logic                rd_last,
  // completion
  output logic                done_valid,
  output logic [IDWIDTH-1:0]  done_id,
  output logic [1:0]          done_resp,
  output logic                proto_err,
  // AXI AW
  output logic                awvalid,
  input  logic                awready,
  output logic [AWIDTH-1:0]   awaddr,
  output logic [IDWIDTH-1:0]  awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [3:0]          awqos,
  output logic [3:0]          awregion,
  // AXI W
  output logic                wvalid,
  input  logic                wready,
  output logic [DWIDTH-1:0]   wdata,
  output logic [DWIDTH/8-1:0] wstrb,
  output logic                wlast,
  output logic [IDWIDTH-1:0]  wid,
  // AXI B
  input  logic                bvalid,
  output logic                bready,
  input  logic [IDWIDTH-1:0]  bid,
  input  logic [1:0]          bresp,
  // AXI AR
  output logic                arvalid,
  input  logic                arready,
  output logic [AWIDTH-1:0]   araddr,
  output logic [IDWIDTH-1:0]  arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic [3:0]          arqos,
  output logic [3:0]          arregion,
  // AXI R
  input  logic                rvalid,
  output logic                rready,
  input  logic [IDWIDTH-1:0]  rid,
  input  logic [DWIDTH-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast
);

  localparam logic [2:0] SIZE = 3'($clog2(DWIDTH/8));

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_e;

  state_e               state_q, state_d;
  logic [AWIDTH-1:0]    addr_q, addr_d;
  logic [7:0]           len_q, len_d, beat_q, beat_d;
  logic [IDWIDTH-1:0]   id_q, id_d;
  logic [1:0]           resp_q, resp_d;
  logic                 perr_q, perr_d;
  logic                 awvalid_q, awvalid_d, arvalid_q, arvalid_d;
  logic                 bready_q, bready_d, done_q, done_d;
  logic                 w_hs, r_hs, last_beat, bad;

  assign last_beat = (beat_q == len_q);
  assign w_hs      = (state_q == W) && wd_valid && wready;
  assign r_hs      = (state_q == R) && rvalid && rd_ready;

  // Anything the slave says that does not belong to the current burst.
  assign bad = (bvalid && ((state_q != B) || (bid != id_q))) ||
               (rvalid && ((state_q != R) || (rid != id_q))) ||
               (r_hs && (rlast != last_beat));

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    beat_d      = beat_q;
    resp_d      = resp_q;
    perr_d      = perr_q | bad;
    awvalid_d   = 1'b0;
    arvalid_d   = 1'b0;
    bready_d    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d = cmd_addr;
        len_d  = cmd_len;
        id_d   = cmd_id;
        beat_d = 8'd0;
        resp_d = 2'b00;
        if (cmd_write) begin
          state_d   = AW;
          awvalid_d = 1'b1;
        end else begin
          state_d   = AR;
          arvalid_d = 1'b1;
        end
      end
      AW: if (awready) state_d = W;
          else awvalid_d = 1'b1;
      W: if (w_hs) begin
        beat_d = beat_q + 8'd1;
        if (last_beat) begin
          state_d  = B;
          bready_d = 1'b1;
        end
      end
      B: if (bvalid) begin
        resp_d  = bresp;
        state_d = DONE;
        done_d  = 1'b1;
      end else bready_d = 1'b1;
      AR: if (arready) state_d = R;
          else arvalid_d = 1'b1;
      R: if (r_hs) begin
        beat_d = beat_q + 8'd1;
        // First error response wins; OKAY/EXOKAY never override.
        if (!resp_q[1] && rresp[1]) resp_d = rresp;
        if (last_beat) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, burst context and registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      beat_q    <= '0;
      resp_q    <= '0;
      perr_q    <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      perr_q    <= perr_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE) && resetn;
  assign done_valid = done_q;
  assign done_id    = id_q;
  assign done_resp  = resp_q;
  assign proto_err  = perr_q;

  assign awvalid  = awvalid_q;
  assign awaddr   = addr_q;
  assign awid     = id_q;
  assign awlen    = len_q;
  assign awsize   = SIZE;
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign awqos    = 4'd0;
  assign awregion = 4'd0;

  assign wvalid   = (state_q == W) && wd_valid;
  assign wd_ready = (state_q == W) && wready;
  assign wdata    = wd_data;
  assign wstrb    = wd_strb;
  assign wlast    = (state_q == W) && last_beat;
  assign wid      = id_q;

  assign bready   = bready_q;

  assign arvalid  = arvalid_q;
  assign araddr   = addr_q;
  assign arid     = id_q;
  assign arlen    = len_q;
  assign arsize   = SIZE;
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arqos    = 4'd0;
  assign arregion = 4'd0;

  assign rready   = (state_q == R) && rd_ready;
  assign rd_valid = (state_q == R) && rvalid;
  assign rd_data  = rdata;
  assign rd_resp  = rresp;
  assign rd_last  = rlast;

endmodule

// File: tb/tb_coralnpu_axi_master_engine.sv
// Directed bench for the AXI burst master: a reactive slave/stream driver, a
// transaction-level expectation model checked every cycle, and literal checks
// on latency, IDs and responses for each scenario.
module tb_coralnpu_axi_master_engine;
  logic clk, resetn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [5:0] cmd_id;
  logic wd_valid, wd_ready;
  logic [127:0] wd_data;
  logic [15:0] wd_strb;
  logic rd_valid, rd_ready, rd_last;
  logic [127:0] rd_data;
  logic [1:0] rd_resp;
  logic done_valid, proto_err;
  logic [5:0] done_id;
  logic [1:0] done_resp;
  logic awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, arlock, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr;
  logic [5:0] awid, wid, bid, arid, rid;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] awcache, awqos, awregion, arcache, arqos, arregion;
  logic [127:0] wdata, rdata;
  logic [15:0] wstrb;

  coralnpu_axi_master_engine dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
    .rd_last(rd_last),
    .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp),
    .proto_err(proto_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awqos(awqos), .awregion(awregion),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wid(wid),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arqos(arqos), .arregion(arregion),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Expectation model of the current burst.
  bit   exp_write;
  logic [31:0] exp_addr;
  int   exp_len, exp_id;
  bit   cmd_acc, aw_seen, ar_seen, b_done, done_due, exp_perr;
  int   wcount, rcount;

  // Slave / stream configuration and bookkeeping.
  int   aw_wait, stall_beat, rstall, rid_bad, wbeat, rbeat;
  bit   r_active;
  logic [1:0] cfg_bresp;
  logic [1:0] cfg_rresp [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] wd_of(int id, int k);
    return {32'hC0DE_0000 + 32'(id * 256 + k), 32'h1111_1111 * 32'(k + 1), ~32'(k), 32'(id)};
  endfunction

  function automatic logic [127:0] rd_of(int id, int k);
    return {32'hBEEF_0000 + 32'(id * 256 + k), ~32'(k * 3), 32'h0F0F_0000 + 32'(k), 32'(id + 7)};
  endfunction

  // Slave and stream driver: react to outputs at negedge, record handshakes at +1.
  initial begin
    awready = 0; arready = 0; wready = 0; bvalid = 0; rvalid = 0; rd_ready = 0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; bid = '0; bresp = '0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        r_active = 0; awready = 0; arready = 0; bvalid = 0; rvalid = 0;
      end else begin
        awready = awvalid && (aw_wait == 0);
        if (awvalid && aw_wait > 0) aw_wait--;
        arready = arvalid;
        wready = 1; wd_valid = 1; wd_data = wd_of(exp_id, wbeat); wd_strb = '1;
        bvalid = bready; bid = 6'(exp_id); bresp = cfg_bresp;
        rd_ready = !(rbeat == stall_beat && rstall < 3);
        if (!rd_ready) rstall++;
        rvalid = r_active; rdata = rd_of(exp_id, rbeat); rresp = cfg_rresp[rbeat % 8];
        rid = 6'(exp_id + rid_bad); rlast = (rbeat == exp_len);
        #1;
        if (arvalid && arready) r_active = 1;
        if (wvalid && wready) wbeat++;
        if (rvalid && rready) begin
          if (rbeat == exp_len) r_active = 0;
          rbeat++;
        end
      end
    end
  end

  // Compare process: every cycle, outputs against the burst-level expectations.
  initial begin
    bit aw_ph, w_ph, b_ph, ar_ph, r_ph;
    logic [1:0] er;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        cmd_acc = 0; aw_seen = 0; ar_seen = 0; b_done = 0; done_due = 0; exp_perr = 0;
      end else begin
        aw_ph = cmd_acc && exp_write && !aw_seen;
        w_ph  = cmd_acc && exp_write && aw_seen && wcount <= exp_len;
        b_ph  = cmd_acc && exp_write && wcount > exp_len && !b_done;
        ar_ph = cmd_acc && !exp_write && !ar_seen;
        r_ph  = cmd_acc && !exp_write && ar_seen && rcount <= exp_len;
        chk("cmd_ready", 128'(cmd_ready), 128'(!cmd_acc));
        chk("proto_err", 128'(proto_err), 128'(exp_perr));
        chk("done_valid", 128'(done_valid), 128'(done_due));
        chk("awvalid", 128'(awvalid), 128'(aw_ph));
        chk("wvalid", 128'(wvalid), 128'(w_ph));
        chk("wd_ready", 128'(wd_ready), 128'(w_ph && wready));
        chk("bready", 128'(bready), 128'(b_ph));
        chk("arvalid", 128'(arvalid), 128'(ar_ph));
        chk("rready", 128'(rready), 128'(r_ph && rd_ready));
        chk("rd_valid", 128'(rd_valid), 128'(r_ph && rvalid));
        if (awvalid) begin
          chk("awaddr", 128'(awaddr), 128'(exp_addr));
          chk("awid", 128'(awid), 128'(exp_id));
          chk("awlen", 128'(awlen), 128'(exp_len));
          chk("awsize", 128'(awsize), 128'(4));
          chk("awburst", 128'(awburst), 128'(1));
          chk("aw_zero", 128'({awlock, awcache, awprot, awqos, awregion}), 128'(0));
        end
        if (arvalid) begin
          chk("araddr", 128'(araddr), 128'(exp_addr));
          chk("arid", 128'(arid), 128'(exp_id));
          chk("arlen", 128'(arlen), 128'(exp_len));
          chk("arsize", 128'(arsize), 128'(4));
          chk("arburst", 128'(arburst), 128'(1));
          chk("ar_zero", 128'({arlock, arcache, arprot, arqos, arregion}), 128'(0));
        end
        if (wvalid && wready) begin
          chk("wdata", wdata, wd_of(exp_id, wcount));
          chk("wstrb", 128'(wstrb), 128'(16'hFFFF));
          chk("wid", 128'(wid), 128'(exp_id));
          chk("wlast", 128'(wlast), 128'(wcount == exp_len));
        end
        if (rd_valid && rd_ready) begin
          chk("rd_data", rd_data, rd_of(exp_id, rcount));
          chk("rd_resp", 128'(rd_resp), 128'(cfg_rresp[rcount % 8]));
          chk("rd_last", 128'(rd_last), 128'(rcount == exp_len));
        end
        if (done_valid) begin
          er = 2'b00;
          if (exp_write) er = cfg_bresp;
          else for (int i = exp_len; i >= 0; i--) if (cfg_rresp[i % 8][1]) er = cfg_rresp[i % 8];
          chk("done_id", 128'(done_id), 128'(exp_id));
          chk("done_resp", 128'(done_resp), 128'(er));
          chk("beats", 128'(exp_write ? wcount : rcount), 128'(exp_len + 1));
        end
        done_due = 0;
        if (awvalid && awready) aw_seen = 1;
        if (wvalid && wready) wcount++;
        if (bvalid && bready) begin b_done = 1; done_due = 1; end
        if (arvalid && arready) ar_seen = 1;
        if (rvalid && rready) begin
          if (rcount == exp_len) done_due = 1;
          rcount++;
        end
        if (done_valid) cmd_acc = 0;
        if (rvalid && rid != 6'(exp_id)) exp_perr = 1;
        if (bvalid && bid != 6'(exp_id)) exp_perr = 1;
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a, input int len, input int id);
    @(negedge clk);
    exp_write = wr; exp_addr = a; exp_len = len; exp_id = id;
    aw_seen = 0; ar_seen = 0; b_done = 0; done_due = 0; wcount = 0; rcount = 0;
    wbeat = 0; rbeat = 0; rstall = 0; r_active = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = 8'(len); cmd_id = 6'(id);
    @(negedge clk);
    cmd_valid = 0; cmd_acc = 1;
  endtask

  task automatic wait_done(output int lat, output logic [1:0] resp, output logic [5:0] id);
    lat = -1; resp = 'x; id = 'x;
    for (int k = 1; k < 400; k++) begin
      #3;
      if (done_valid === 1'b1) begin
        lat = k; resp = done_resp; id = done_id;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout act=none exp=done_valid t=%0t", $time);
    end
  endtask

  initial begin
    int lat;
    logic [1:0] r;
    logic [5:0] id;
    resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    aw_wait = 0; stall_beat = -1; rid_bad = 0; cfg_bresp = 2'b00;
    exp_len = 0; exp_id = 0; exp_addr = '0; exp_write = 0;
    for (int i = 0; i < 8; i++) cfg_rresp[i] = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_valids", 128'({awvalid, arvalid, wvalid, bready, rready, done_valid, rd_valid, wd_ready}), 128'(0));
    chk("rst_proto_err", 128'(proto_err), 128'(0));
    chk("rst_regs", 128'({awaddr, awid, awlen, done_id, done_resp}), 128'(0));
    @(negedge clk);
    resetn = 1;

    // Write len=3, addr 0x1000, id 5, slave always ready.
    issue(1, 32'h1000, 3, 5);
    wait_done(lat, r, id);
    chk("t1_lat", 128'(lat), 128'(7));
    chk("t1_id", 128'(id), 128'(5));
    chk("t1_resp", 128'(r), 128'(0));

    // Single-beat write: minimum latency.
    issue(1, 32'h2000, 0, 9);
    wait_done(lat, r, id);
    chk("t2_lat", 128'(lat), 128'(4));

    // Read len=7 with SLVERR on beat 2.
    cfg_rresp[2] = 2'b10;
    issue(0, 32'h3000, 7, 3);
    wait_done(lat, r, id);
    chk("t3_lat", 128'(lat), 128'(10));
    chk("t3_resp", 128'(r), 128'(2'b10));
    cfg_rresp[2] = 2'b00;

    // AW stalled 10 cycles.
    aw_wait = 10;
    issue(1, 32'h2040, 0, 12);
    wait_done(lat, r, id);
    chk("t4_lat", 128'(lat), 128'(14));
    chk("t4_id", 128'(id), 128'(12));

    // Read with rd_ready dropped for 3 cycles at beat 3; first error kept.
    stall_beat = 3;
    cfg_rresp[4] = 2'b11; cfg_rresp[5] = 2'b10;
    issue(0, 32'h5000, 5, 33);
    wait_done(lat, r, id);
    chk("t5_lat", 128'(lat), 128'(11));
    chk("t5_resp", 128'(r), 128'(2'b11));
    stall_beat = -1;
    for (int i = 0; i < 8; i++) cfg_rresp[i] = 2'b00;

    // Wrong rid: proto_err sticky, burst still completes.
    rid_bad = 1;
    issue(0, 32'h6000, 1, 5);
    wait_done(lat, r, id);
    chk("t6_lat", 128'(lat), 128'(4));
    rid_bad = 0;
    @(negedge clk); #3;
    chk("t6_perr", 128'(proto_err), 128'(1));
    issue(1, 32'h6100, 0, 7);
    wait_done(lat, r, id);
    chk("t6_perr_held", 128'(proto_err), 128'(1));

    // Reset during W beat 2 of a len=7 write.
    issue(1, 32'h7000, 7, 2);
    for (int k = 0; k < 50; k++) begin
      if (wcount == 2) break;
      @(negedge clk); #3;
    end
    @(negedge clk);
    resetn = 0;
    #1;
    chk("t7_valids", 128'({awvalid, arvalid, wvalid, bready, rready, done_valid, rd_valid, wd_ready}), 128'(0));
    chk("t7_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("t7_perr", 128'(proto_err), 128'(0));
    @(negedge clk);
    resetn = 1;
    issue(1, 32'h4000, 2, 4);
    wait_done(lat, r, id);
    chk("t7_lat", 128'(lat), 128'(6));
    chk("t7_id", 128'(id), 128'(4));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
